// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int OVERSAMPLE_DEF  = 16;
    localparam int OVERSAMPLE_HALF = OVERSAMPLE_DEF / 2;
    // Wide enough to index up to 16 payload bits.
    localparam int BIT_CNT_W       = 4;

    // Rounded clock divider giving one tick per oversample period.
    function automatic int div_calc(input int clk_freq, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous clear realigns the count to an external event (start edge).
module uart_baud_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Free-running divider, restarted by rst, clr or terminal count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, oversampled with centre-of-bit sampling.
//
//   state | meaning
//   IDLE  | line high, waiting for a falling edge on rx_s
//   START | counting to the start-bit centre; line high there means glitch
//   DATA  | sampling payload bits one bit period apart, LSB first
//   STOP  | sampling the stop bit; high = good byte, low = framing error
//   BREAK | line stuck low after a framing error; wait for it to rise
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV  = div_calc(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]      OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    uart_state_t          state;
    uart_state_t          state_nxt;
    logic                 tick;
    logic                 baud_clr;
    logic                 os_clr;
    logic                 shift_en;
    logic                 frame_ok;
    logic                 frame_bad;
    logic [OS_W-1:0]      os;
    logic [BIT_CNT_W-1:0] bit_idx;
    logic [DATA_BITS-1:0] shift;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    // Two-flop synchroniser on the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (tick && os == OS_MID) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (shift_en && bit_idx == BIT_LAST) state_nxt = STOP;
            end
            STOP: begin
                if (tick && os == OS_LAST) state_nxt = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        baud_clr  = 1'b0;
        os_clr    = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                os_clr   = 1'b1;
                baud_clr = !rx_s;
            end
            START: begin
                if (tick && os == OS_MID) os_clr = 1'b1;
            end
            DATA: begin
                if (tick && os == OS_LAST) begin
                    os_clr   = 1'b1;
                    shift_en = 1'b1;
                end
            end
            STOP: begin
                if (tick && os == OS_LAST) begin
                    os_clr    = 1'b1;
                    frame_ok  = rx_s;
                    frame_bad = !rx_s;
                end
            end
            BREAK: begin
                os_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // Oversample/bit counters, shift register and registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            os        <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= frame_ok;
            frame_err <= frame_bad;
            if (os_clr) begin
                os <= '0;
            end else if (tick) begin
                os <= os + OS_W'(1);
            end
            if (shift_en) begin
                bit_idx <= bit_idx + BIT_CNT_W'(1);
            end else if (state != DATA) begin
                bit_idx <= '0;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[DATA_BITS-1:1]};
            end
            if (frame_ok) begin
                rx_data <= shift;
            end
        end
    end

endmodule
